// File: rtl/parallax_layers.sv
// Procedural starfield plus NUM_LAYERS scrolling ridge layers inside a square area.
// The layers are composited by priority into a registered RGB pixel.
module parallax_layers #(
  parameter int NUM_LAYERS = 3,
  parameter int AREA_LOG2 = 8,
  parameter int LFSR_W = 16,
  parameter int STAR_THRESH = 9,
  parameter int BASE_HEIGHT = 200,
  parameter int MIN_HEIGHT = 16,
  parameter int RGB_W = 3,
  parameter logic [4*RGB_W-1:0] LAYER_COLORS = 12'h362
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       hpos,
  input  logic [9:0]       vpos,
  input  logic             display_on,
  input  logic             pause,
  input  logic [1:0]       speed_sel,
  output logic [RGB_W-1:0] rgb,
  output logic [7:0]       frame
);

  localparam logic [9:0] AREA_SIZE  = 10'(1 << AREA_LOG2);
  localparam logic [9:0] MAX_H      = 10'((1 << AREA_LOG2) - 1);
  localparam logic [9:0] MIN_H      = 10'(MIN_HEIGHT);
  localparam logic [7:0] LAYER_TAPS = 8'hB8;

  function automatic logic [LFSR_W-1:0] star_taps();
    case (LFSR_W)
      16:      return LFSR_W'(16'hB400);
      15:      return LFSR_W'(16'h6000);
      14:      return LFSR_W'(16'h3802);
      default: return LFSR_W'(16'hB400);
    endcase
  endfunction

  localparam logic [LFSR_W-1:0] STAR_TAPS = star_taps();

  function automatic logic [LFSR_W-1:0] star_step(input logic [LFSR_W-1:0] x);
    return {1'b0, x[LFSR_W-1:1]} ^ (x[0] ? STAR_TAPS : {LFSR_W{1'b0}});
  endfunction

  function automatic logic [7:0] layer_step(input logic [7:0] x);
    return {1'b0, x[7:1]} ^ (x[0] ? LAYER_TAPS : 8'h00);
  endfunction

  // Saturating +/-1 so ridges never wrap through the top or bottom of the area
  function automatic logic [9:0] height_step(input logic [9:0] h, input logic up);
    if (up) begin
      return (h >= MAX_H) ? MAX_H : h + 10'd1;
    end else begin
      return (h <= MIN_H) ? MIN_H : h - 10'd1;
    end
  endfunction

  logic                                area_en_s;
  logic                                star_s;
  logic [RGB_W-1:0]                    star_col_s;
  logic [RGB_W-1:0]                    pix_s;
  logic [RGB_W-1:0]                    rgb_r;
  logic [7:0]                          frame_r;
  logic [LFSR_W-1:0]                   star_lfsr_r;
  logic [NUM_LAYERS-1:0][7:0]          seed_lfsr_r;
  logic [NUM_LAYERS-1:0][7:0]          work_lfsr_r;
  logic [NUM_LAYERS-1:0][9:0]          seed_height_r;
  logic [NUM_LAYERS-1:0][9:0]          work_height_r;
  logic [NUM_LAYERS-1:0]               seed_step_s;
  logic [NUM_LAYERS-1:0]               work_step_s;

  assign area_en_s  = display_on && (hpos < AREA_SIZE) && (vpos < AREA_SIZE);
  assign star_s     = &star_lfsr_r[LFSR_W-1 -: STAR_THRESH];
  assign star_col_s = {star_lfsr_r[RGB_W-1:1], 1'b1};
  assign rgb        = rgb_r;
  assign frame      = frame_r;

  // Per-layer step enables: seed walker bursts on line 1, row walker stretches by 2^k
  always_comb begin
    seed_step_s = {NUM_LAYERS{1'b0}};
    work_step_s = {NUM_LAYERS{1'b0}};
    for (int k = 0; k < NUM_LAYERS; k++) begin
      seed_step_s[k] = (vpos == 10'd1) && !pause &&
                       (hpos < 10'(k + 1) * ({8'd0, speed_sel} + 10'd1));
      work_step_s[k] = area_en_s && ((hpos & 10'((1 << k) - 1)) == 10'd0);
    end
  end

  // Priority compositing: nearest covering layer, else star, else black
  always_comb begin
    pix_s = {RGB_W{1'b0}};
    if (area_en_s) begin
      if (star_s) begin
        pix_s = star_col_s;
      end else begin
        pix_s = {RGB_W{1'b0}};
      end
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
        if (vpos > work_height_r[k]) begin
          pix_s = LAYER_COLORS[k*RGB_W +: RGB_W];
        end else begin
          pix_s = pix_s;
        end
      end
    end else begin
      pix_s = {RGB_W{1'b0}};
    end
  end

  // Output pixel, frame counter and free-running star generator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_r       <= {RGB_W{1'b0}};
      frame_r     <= 8'd0;
      star_lfsr_r <= {LFSR_W{1'b1}};
    end else begin
      rgb_r <= pix_s;
      if (hpos == 10'd0 && vpos == 10'd0 && !pause) begin
        frame_r <= frame_r + 8'd1;
      end
      if (area_en_s) begin
        star_lfsr_r <= star_step(star_lfsr_r);
      end
    end
  end

  // Ridge walkers; the row walker reloads from the seed at each line start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        seed_lfsr_r[k]   <= 8'(8'h60 + k);
        work_lfsr_r[k]   <= 8'(8'h60 + k);
        seed_height_r[k] <= 10'(BASE_HEIGHT - 20 * k);
        work_height_r[k] <= 10'(BASE_HEIGHT - 20 * k);
      end
    end else begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (seed_step_s[k]) begin
          seed_lfsr_r[k]   <= layer_step(seed_lfsr_r[k]);
          seed_height_r[k] <= height_step(seed_height_r[k], seed_lfsr_r[k][0]);
        end
        if (hpos == 10'd0) begin
          work_lfsr_r[k]   <= seed_lfsr_r[k];
          work_height_r[k] <= seed_height_r[k];
        end else if (work_step_s[k]) begin
          work_lfsr_r[k]   <= layer_step(work_lfsr_r[k]);
          work_height_r[k] <= height_step(work_height_r[k], work_lfsr_r[k][0]);
        end
      end
    end
  end

endmodule

// File: tb/tb_parallax_layers.sv
// Scoreboard bench for parallax_layers: a reference model pushes the expected
// pixel for every driven position; each test pops and compares one cycle later.
module tb_parallax_layers;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       pause;
  logic [1:0] speed_sel;
  logic [2:0] rgb;
  logic [2:0] rgb_c;
  logic [7:0] frame;
  logic [7:0] frame_c;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  parallax_layers dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .pause(pause), .speed_sel(speed_sel), .rgb(rgb), .frame(frame)
  );

  parallax_layers #(.BASE_HEIGHT(17)) dut_c (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .pause(pause), .speed_sel(speed_sel), .rgb(rgb_c), .frame(frame_c)
  );

  // Reference model state
  logic [2:0]  sb_q[$];
  logic [15:0] m_star;
  logic [7:0]  m_frame;
  logic [7:0]  m_seed_l[3];
  logic [7:0]  m_work_l[3];
  logic [9:0]  m_seed_h[3];
  logic [9:0]  m_work_h[3];
  logic [2:0]  m_col[3];

  function automatic logic [7:0] m_lstep(input logic [7:0] x);
    if (x[0]) return (x >> 1) ^ 8'hB8;
    else return x >> 1;
  endfunction

  function automatic logic [15:0] m_sstep(input logic [15:0] x);
    if (x[0]) return (x >> 1) ^ 16'hB400;
    else return x >> 1;
  endfunction

  function automatic logic [9:0] m_hstep(input logic [9:0] h, input logic up);
    if (up) return (h >= 10'd255) ? h : h + 10'd1;
    else return (h <= 10'd16) ? h : h - 10'd1;
  endfunction

  task automatic model_reset();
    m_star  = 16'hFFFF;
    m_frame = 8'd0;
    m_col[0] = 3'b010; m_col[1] = 3'b100; m_col[2] = 3'b101;
    for (int k = 0; k < 3; k++) begin
      m_seed_l[k] = 8'(8'h60 + k);
      m_work_l[k] = 8'(8'h60 + k);
      m_seed_h[k] = 10'(200 - 20 * k);
      m_work_h[k] = 10'(200 - 20 * k);
    end
    sb_q.delete();
  endtask

  task automatic drive_pixel(input int h, input int v, input logic d);
    logic [2:0] e;
    logic       area;
    logic       hit;
    logic [7:0] old_seed_l[3];
    logic [9:0] old_seed_h[3];
    hpos = 10'(h); vpos = 10'(v); display_on = d;
    area = d && (h < 256) && (v < 256);
    e = 3'b000;
    hit = 1'b0;
    if (area) begin
      for (int k = 0; k < 3; k++) begin
        if (!hit && v > int'(m_work_h[k])) begin
          e = m_col[k];
          hit = 1'b1;
        end
      end
      if (!hit && (&m_star[15:7])) e = {m_star[2:1], 1'b1};
    end
    sb_q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      old_seed_l[k] = m_seed_l[k];
      old_seed_h[k] = m_seed_h[k];
      if (v == 1 && !pause && h < (k + 1) * (int'(speed_sel) + 1)) begin
        m_seed_h[k] = m_hstep(m_seed_h[k], m_seed_l[k][0]);
        m_seed_l[k] = m_lstep(m_seed_l[k]);
      end
      if (h == 0) begin
        m_work_l[k] = old_seed_l[k];
        m_work_h[k] = old_seed_h[k];
      end else if (area && (h % (1 << k)) == 0) begin
        m_work_h[k] = m_hstep(m_work_h[k], m_work_l[k][0]);
        m_work_l[k] = m_lstep(m_work_l[k]);
      end
    end
    if (h == 0 && v == 0 && !pause) m_frame = m_frame + 8'd1;
    if (area) m_star = m_sstep(m_star);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic compressed_frame();
    logic [2:0] e;
    drive_pixel(0, 0, 1'b0);
    e = sb_q.pop_front(); checks++;
    if (rgb !== e) $display("FAIL frame_rgb: got %b expected %b", rgb, e); else passed++;
    for (int h = 0; h < 20; h++) begin
      drive_pixel(h, 1, 1'b0);
      e = sb_q.pop_front(); checks++;
      if (rgb !== e) $display("FAIL scroll_rgb: got %b expected %b", rgb, e); else passed++;
    end
    drive_pixel(0, 2, 1'b0);
    e = sb_q.pop_front(); checks++;
    if (rgb !== e) $display("FAIL frame_rgb: got %b expected %b", rgb, e); else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rgb !== 3'b000) $display("FAIL reset_rgb: got %b expected 000", rgb); else passed++;
    checks++; if (frame !== 8'd0) $display("FAIL reset_frame: got %0d expected 0", frame); else passed++;
    checks++; if (dut.star_lfsr_r !== 16'hFFFF) $display("FAIL reset_star: got %h expected ffff", dut.star_lfsr_r); else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut.seed_height_r[k] !== 10'(200 - 20 * k))
        $display("FAIL reset_height%0d: got %0d expected %0d", k, dut.seed_height_r[k], 200 - 20 * k);
      else passed++;
      checks++;
      if (dut.seed_lfsr_r[k] !== 8'(8'h60 + k))
        $display("FAIL reset_seed%0d: got %h expected %h", k, dut.seed_lfsr_r[k], 8'(8'h60 + k));
      else passed++;
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_frame_pause();
    logic [7:0] saved_l[3];
    logic [9:0] saved_h[3];
    speed_sel = 2'd0;
    repeat (3) compressed_frame();
    checks++; if (frame !== 8'd3) $display("FAIL frame_count: got %0d expected 3", frame); else passed++;
    for (int k = 0; k < 3; k++) begin
      saved_l[k] = m_seed_l[k];
      saved_h[k] = m_seed_h[k];
    end
    pause = 1'b1;
    compressed_frame();
    pause = 1'b0;
    checks++; if (frame !== 8'd3) $display("FAIL pause_frame: got %0d expected 3", frame); else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut.seed_lfsr_r[k] !== saved_l[k] || dut.seed_height_r[k] !== saved_h[k])
        $display("FAIL pause_seed%0d: got %h/%0d expected %h/%0d", k,
                 dut.seed_lfsr_r[k], dut.seed_height_r[k], saved_l[k], saved_h[k]);
      else passed++;
    end
  endtask

  task automatic test_priority();
    logic [2:0] e;
    drive_pixel(10, 255, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (rgb !== e) $display("FAIL prio_layer0: got %b expected %b", rgb, e); else passed++;
    drive_pixel(10, 255, 1'b0);
    e = sb_q.pop_front(); checks++;
    if (rgb !== e) $display("FAIL prio_display_off: got %b expected %b", rgb, e); else passed++;
    // Rows below each ridge and one in the sky exercise every priority level
    for (int r = 0; r < 4; r++) begin
      int v;
      v = (r == 0) ? 255 : (r == 1) ? 190 : (r == 2) ? 170 : 50;
      for (int h = 0; h < 300; h++) begin
        drive_pixel(h, v, 1'b1);
        e = sb_q.pop_front(); checks++;
        if (rgb !== e) $display("FAIL prio_row: v=%0d h=%0d got %b expected %b", v, h, rgb, e);
        else passed++;
      end
    end
  endtask

  task automatic test_area_edge();
    logic [2:0]  e;
    logic [15:0] star_before;
    drive_pixel(255, 255, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (rgb !== e) $display("FAIL edge_in: got %b expected %b", rgb, e); else passed++;
    drive_pixel(256, 255, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (rgb !== e) $display("FAIL edge_out: got %b expected %b", rgb, e); else passed++;
    star_before = m_star;
    for (int h = 256; h < 280; h++) begin
      drive_pixel(h, 10, 1'b1);
      e = sb_q.pop_front(); checks++;
      if (rgb !== e) $display("FAIL edge_rgb: got %b expected %b", rgb, e); else passed++;
    end
    checks++;
    if (dut.star_lfsr_r !== star_before)
      $display("FAIL edge_star_hold: got %h expected %h", dut.star_lfsr_r, star_before);
    else passed++;
  endtask

  task automatic test_reset_midline();
    logic [2:0] e;
    drive_pixel(10, 255, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (rgb !== e) $display("FAIL midline_pre: got %b expected %b", rgb, e); else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rgb !== 3'b000) $display("FAIL midline_rgb: got %b expected 000", rgb); else passed++;
    checks++; if (frame !== 8'd0) $display("FAIL midline_frame: got %0d expected 0", frame); else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut.seed_height_r[k] !== 10'(200 - 20 * k))
        $display("FAIL midline_height%0d: got %0d expected %0d", k, dut.seed_height_r[k], 200 - 20 * k);
      else passed++;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_scroll();
    logic [7:0] exp_l;
    logic [9:0] exp_h;
    do_reset();
    speed_sel = 2'd1;
    compressed_frame();
    speed_sel = 2'd0;
    for (int k = 0; k < 3; k++) begin
      exp_l = 8'(8'h60 + k);
      exp_h = 10'(200 - 20 * k);
      for (int s = 0; s < 2 * (k + 1); s++) begin
        exp_h = m_hstep(exp_h, exp_l[0]);
        exp_l = m_lstep(exp_l);
      end
      checks++;
      if (dut.seed_lfsr_r[k] !== exp_l || dut.seed_height_r[k] !== exp_h)
        $display("FAIL scroll_seed%0d: got %h/%0d expected %h/%0d", k,
                 dut.seed_lfsr_r[k], dut.seed_height_r[k], exp_l, exp_h);
      else passed++;
    end
  endtask

  task automatic test_clamp();
    logic [2:0] e;
    logic [9:0] exp_h[4];
    exp_h[0] = 10'd17; exp_h[1] = 10'd16; exp_h[2] = 10'd16; exp_h[3] = 10'd16;
    do_reset();
    for (int h = 0; h < 4; h++) begin
      drive_pixel(h, 100, 1'b1);
      e = sb_q.pop_front(); checks++;
      if (rgb !== e) $display("FAIL clamp_rgb: got %b expected %b", rgb, e); else passed++;
      checks++;
      if (dut_c.work_height_r[0] !== exp_h[h])
        $display("FAIL clamp_height: h=%0d got %0d expected %0d", h, dut_c.work_height_r[0], exp_h[h]);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b0;
    hpos = 10'd0;
    vpos = 10'd600;
    display_on = 1'b0;
    pause = 1'b0;
    speed_sel = 2'd0;
    test_reset();
    test_frame_pause();
    test_priority();
    test_area_edge();
    test_reset_midline();
    test_scroll();
    test_clamp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/parallax_layers.md
Name: parallax_layers

Overview:
- Parametrised successor to the single-layer LFSR scrolling background.
- Generates a procedural starfield plus NUM_LAYERS parallax ridge ("mountain") layers inside a 2^AREA_LOG2-pixel square.
- Adds per-layer scroll speed, a global speed select, a pause control, clamped ridge heights, priority compositing and a registered output.
- Sits between the VGA sync generator, which supplies hpos/vpos/display_on, and the pad outputs.

Parameters:
- NUM_LAYERS, 3: number of ridge layers (1..4); layer 0 is nearest.
- AREA_LOG2, 8: active square side = 2^AREA_LOG2 pixels (6..9).
- LFSR_W, 16: star LFSR width (14, 15 or 16).
- STAR_THRESH, 9: a star is lit when the top STAR_THRESH LFSR bits are all ones.
- BASE_HEIGHT, 200: reset ridge height of layer 0; layer k resets to BASE_HEIGHT-20*k.
- MIN_HEIGHT, 16: lower clamp for ridge height.
- RGB_W, 3: colour width.
- LAYER_COLORS, 12'h362: packed 4 x RGB_W palette; layer k colour = LAYER_COLORS[k*RGB_W +: RGB_W] (defaults: L0=010, L1=100, L2=101, L3=001).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- hpos  in  10  current pixel x from sync generator.
- vpos  in  10  current pixel y from sync generator.
- display_on  in  1  active video.
- pause  in  1  1 = freeze frame counter and layer scrolling.
- speed_sel  in  2  global scroll multiplier (speed_sel+1).
- rgb  out  RGB_W  pixel colour, registered.
- frame  out  8  frame counter.

Behaviour:
- Async reset (reset=0) values:
  - rgb=0, frame=0.
  - Star LFSR = all ones.
  - Layer k seed and working LFSRs = 8'h60+k.
  - Layer k seed and working heights = BASE_HEIGHT-20*k.
- area_en = display_on & (hpos < 2^AREA_LOG2) & (vpos < 2^AREA_LOG2).
- All LFSRs are Galois right-shift: x <= (x>>1) ^ (x[0] ? TAPS : 0).
  - Star TAPS: 16:0xB400, 15:0x6000, 14:0x3802.
  - Layer LFSRs: 8-bit, TAPS 0xB8.
  - No LFSR ever reaches zero.
- frame: +1 when hpos==0 && vpos==0 && !pause; wraps 255->0.
- Star LFSR:
  - Steps every cycle area_en=1 and is never reseeded per frame.
  - The area holds 2^(2*AREA_LOG2) pixels, one more than the LFSR period when AREA_LOG2=8, LFSR_W=16, so the field drifts one pixel per frame.
  - star = &lfsr[LFSR_W-1 -: STAR_THRESH]; star colour = {lfsr[RGB_W-1:1],1'b1}.
- Layer scroll (seed walker, per layer k):
  - Steps every cycle while vpos==1 && hpos < S_k && !pause, with S_k=(k+1)*(speed_sel+1) (max 16).
  - Step: seed_lfsr advances once; seed_height += seed_lfsr[0] ? +1 : -1 (bit sampled before the advance).
- Row walker (working, per layer k):
  - At hpos==0: working lfsr/height <= seed values. Load has priority over a step in the same cycle.
  - Otherwise steps when area_en && (hpos mod 2^k)==0, so farther layers stretch horizontally.
  - Same step rule as the seed walker; no pause gating.
- Height arithmetic:
  - 10-bit, saturating to [MIN_HEIGHT, 2^AREA_LOG2-1].
  - An increment at max holds; a decrement at MIN_HEIGHT holds. No wrap.
- Coverage: layer k covers the pixel when area_en && vpos > working_height_k, using the value before this cycle's update.
- Compositing, priority:
  - Lowest covering k wins -> LAYER_COLORS[k].
  - Else star -> star colour.
  - Else 0.
  - !area_en -> 0.
- Latency: rgb reflects the hpos/vpos/display_on sampled on the previous clk edge, i.e. 1 cycle.
- Changing speed_sel or pause mid-line takes effect from the next cycle; a partially completed vpos==1 burst stays partial.
- Reset mid-frame: all state returns to reset values immediately; normal operation resumes on the first clk edge after release.

Test Plan:
- Reset: drive reset=0 mid-line with rgb nonzero -> rgb=0 and frame=0 without a clock edge. Layer0/1/2 heights read 200/180/160.
- Frame/pause: sweep 3 full 800x525 frames -> frame=3. With pause=1, one more frame -> frame=3 and seed LFSRs/heights unchanged.
- Scroll count: speed_sel=1, NUM_LAYERS=3, one frame -> seed LFSRs advanced exactly 2/4/6 steps from 8'h60/8'h61/8'h62, matching the model, with heights moved by the matching +/-1 sums.
- Priority/latency: pixel hpos=10, vpos=255 (below all ridges) -> rgb=3'b010 on the next cycle. Same pixel with display_on=0 -> rgb=0.
- Area edge: hpos=255 vs hpos=256 at vpos=255 -> layer colour vs 0. Star LFSR does not step for hpos>=256 (state compare).
- Clamp: BASE_HEIGHT=17 with a seed whose next two steps decrement -> layer0 height 16 then holds at 16. Never 15 or wrapped to 1023.
